proc_fetch: RTL and testbench

PROC_FETCH -- requirements
Module: proc_fetch

---
 rtl/proc_fetch_if.sv | 22 ++
 rtl/proc_fetch.sv | 82 ++++++++
 tb/tb_proc_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/proc_fetch_if.sv
// proc_fetch_if: fetch-unit bus bundle (instruction memory, decode handshake, redirect/halt control).
// master = fetch unit, slave = memory/decode/execute environment.
interface proc_fetch_if;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        inst_val;
    logic        inst_rdy;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        halt_req;
    modport master (
        output imemreq_val, imemreq_addr, inst_val, inst_data, inst_pc,
        input  imemresp_data, inst_rdy, redirect_val, redirect_pc, halt_req
    );
    modport slave (
        input  imemreq_val, imemreq_addr, inst_val, inst_data, inst_pc,
        output imemresp_data, inst_rdy, redirect_val, redirect_pc, halt_req
    );
endinterface

// File: rtl/proc_fetch.sv
// proc_fetch: instruction fetch unit with a DEPTH-entry circular instruction queue.
// Define PROC_FETCH_BYPASS_EN to let a fetched word reach decode in the same cycle when the queue is empty.
module proc_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input logic           clk,
    input logic           rst_n,
    proc_fetch_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];
    logic            q_val, fetch, byp, enq, deq;
    logic            unused_rpc;

    assign unused_rpc = ^bus.redirect_pc[1:0];

    always_comb begin
        q_val = (count_q != '0) && !bus.redirect_val;
        fetch = (state_q == RUN) && !bus.redirect_val && !bus.halt_req &&
                ((count_q < CW'(DEPTH)) || (q_val && bus.inst_rdy));
`ifdef PROC_FETCH_BYPASS_EN
        byp   = fetch && (count_q == '0);
`else
        byp   = 1'b0;
`endif
        deq   = q_val && bus.inst_rdy;
        // A bypassed word that decode takes right away never occupies a slot.
        enq   = fetch && !(byp && bus.inst_rdy);
        state_d = (state_q == BOOT || bus.redirect_val) ? RUN :
                  (state_q == RUN && bus.halt_req)       ? HALT : state_q;
        fpc_d   = bus.redirect_val ? {bus.redirect_pc[31:2], 2'b00} :
                  fetch            ? fpc_q + 32'd4 : fpc_q;
        head_d  = bus.redirect_val ? '0 : deq ? head_q + AW'(1) : head_q;
        tail_d  = bus.redirect_val ? '0 : enq ? tail_q + AW'(1) : tail_q;
        count_d = bus.redirect_val ? '0 : count_q + CW'(enq) - CW'(deq);
    end

    assign bus.imemreq_val  = fetch;
    assign bus.imemreq_addr = fpc_q;
    assign bus.inst_val     = q_val || byp;
    assign bus.inst_data    = byp ? bus.imemresp_data : data_q[head_q];
    assign bus.inst_pc      = byp ? fpc_q : pc_q[head_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            fpc_q   <= RESET_ADDR;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (enq) begin
            data_q[tail_q] <= bus.imemresp_data;
            pc_q[tail_q]   <= fpc_q;
        end
    end
endmodule

// File: tb/tb_proc_fetch.sv
// tb_proc_fetch: directed stimulus for proc_fetch, checked each cycle against a queue-level model
// plus literal expectations for the key scenarios.
module tb_proc_fetch;
    localparam logic [31:0] RA    = 32'h0000_0000;
    localparam int          DEPTH = 2;
`ifdef PROC_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    proc_fetch_if bus();

    proc_fetch #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign bus.imemresp_data = mem_word(bus.imemreq_addr);

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] got_fetch[$];
    logic [31:0] got_pc[$];
    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    bit          m_boot, m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // Model: the queue holds fetched PCs in order; data is implied by mem_word(pc).
    always @(negedge clk) begin : model
        bit qv, fe, bp;
        logic [31:0] hp;
        if (!rst_n) begin
            check("rst_imemreq_val", bus.imemreq_val, 0);
            check("rst_imemreq_addr", bus.imemreq_addr, RA);
            check("rst_inst_val", bus.inst_val, 0);
            check("rst_inst_data", bus.inst_data, 0);
            check("rst_inst_pc", bus.inst_pc, 0);
            m_boot = 1; m_halt = 0; m_fpc = RA; mq.delete();
        end else begin
            qv = mq.size() > 0 && !bus.redirect_val;
            fe = !m_boot && !m_halt && !bus.redirect_val && !bus.halt_req &&
                 (mq.size() < DEPTH || (qv && bus.inst_rdy));
            bp = BYP && fe && mq.size() == 0;
            hp = bp ? m_fpc : (mq.size() > 0 ? mq[0] : 32'h0);
            check("imemreq_val", bus.imemreq_val, fe);
            check("imemreq_addr", bus.imemreq_addr, m_fpc);
            check("inst_val", bus.inst_val, qv || bp);
            if (qv || bp) begin
                check("inst_pc", bus.inst_pc, hp);
                check("inst_data", bus.inst_data, mem_word(hp));
            end
            if (bus.imemreq_val) got_fetch.push_back(bus.imemreq_addr);
            if (bus.inst_val && bus.inst_rdy) got_pc.push_back(bus.inst_pc);
            if (bus.redirect_val) begin
                mq.delete();
                m_fpc = {bus.redirect_pc[31:2], 2'b00};
                m_boot = 0; m_halt = 0;
            end else begin
                if (qv && bus.inst_rdy) void'(mq.pop_front());
                if (fe && !(bp && bus.inst_rdy)) mq.push_back(m_fpc);
                if (fe) m_fpc = m_fpc + 32'd4;
                if (m_boot) m_boot = 0;
                else if (!m_halt && bus.halt_req) m_halt = 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        got_fetch.delete();
        got_pc.delete();
    endtask

    initial begin
        bus.inst_rdy = 1; bus.redirect_val = 0; bus.redirect_pc = 0; bus.halt_req = 0;
        cyc(3);
        // boot and streaming fetch
        rst_n = 1; clear_logs(); cyc(5);
        check("boot_fetch0", at(got_fetch, 0), 32'h0);
        check("boot_fetch1", at(got_fetch, 1), 32'h4);
        check("boot_fetch2", at(got_fetch, 2), 32'h8);
        check("boot_pc0", at(got_pc, 0), 32'h0);
        check("boot_pc1", at(got_pc, 1), 32'h4);
        check("boot_pc2", at(got_pc, 2), 32'h8);
        // stall with decode not ready
        rst_n = 0; bus.inst_rdy = 0; cyc(1);
        rst_n = 1; clear_logs(); cyc(6);
        check("stall_nfetch", got_fetch.size(), 2);
        check("stall_fetch0", at(got_fetch, 0), 32'h0);
        check("stall_fetch1", at(got_fetch, 1), 32'h4);
        bus.inst_rdy = 1;
        @(negedge clk);
        check("release_pc", bus.inst_pc, 32'h0);
        check("release_addr", bus.imemreq_addr, 32'h8);
        check("release_fetch", bus.imemreq_val, 1);
        @(posedge clk); #1;
        // redirect flushes queued 0x10/0x14
        bus.redirect_val = 1; bus.redirect_pc = 32'h10; bus.inst_rdy = 0; cyc(1);
        bus.redirect_val = 0; cyc(3);
        bus.redirect_val = 1; bus.redirect_pc = 32'h43; bus.inst_rdy = 1;
        @(negedge clk);
        check("flush_inst_val", bus.inst_val, 0);
        @(posedge clk); #1;
        bus.redirect_val = 0; clear_logs(); cyc(4);
        check("flush_fetch0", at(got_fetch, 0), 32'h40);
        check("flush_pc0", at(got_pc, 0), 32'h40);
        // halt at fpc 0x20, drain, resume by redirect
        bus.redirect_val = 1; bus.redirect_pc = 32'h18; cyc(1);
        bus.redirect_val = 0; clear_logs(); cyc(2);
        bus.halt_req = 1; cyc(1);
        bus.halt_req = 0; cyc(5);
        check("halt_nfetch", got_fetch.size(), 2);
        check("halt_ndeliv", got_pc.size(), 2);
        check("halt_pc1", at(got_pc, 1), 32'h1C);
        clear_logs();
        bus.redirect_val = 1; bus.redirect_pc = 32'h0; cyc(1);
        bus.redirect_val = 0; cyc(2);
        check("resume_fetch0", at(got_fetch, 0), 32'h0);
        check("resume_fetch1", at(got_fetch, 1), 32'h4);
        // address wrap
        clear_logs();
        bus.redirect_val = 1; bus.redirect_pc = 32'hFFFF_FFFC; cyc(1);
        bus.redirect_val = 0; cyc(2);
        check("wrap_fetch0", at(got_fetch, 0), 32'hFFFF_FFFC);
        check("wrap_fetch1", at(got_fetch, 1), 32'h0);
        // asynchronous reset while an instruction is presented
        bus.inst_rdy = 0; cyc(3);
        check("pre_rst_inst_val", bus.inst_val, 1);
        #2 rst_n = 0;
        #1;
        check("async_inst_val", bus.inst_val, 0);
        check("async_imemreq_val", bus.imemreq_val, 0);
        check("async_inst_pc", bus.inst_pc, 0);
        @(posedge clk); #1;
        rst_n = 1; bus.inst_rdy = 1; clear_logs(); cyc(3);
        check("restart_fetch0", at(got_fetch, 0), RA);
        check("restart_fetch1", at(got_fetch, 1), RA + 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
